cursor_pos_ctrl: RTL and testbench

Cursor position controller for the text editor, directly upstream of the blinking-cursor drawer. It turns decoded keyboard cursor commands into a character-grid position (col, row) and the pixel origin block_x/block_y that the drawer consumes. Before every move it drives blink low long enough for the drawer to erase the cursor at the old cell. Only then does it publish the new position and re-enable blinking.

---
 rtl/cursor_pos_ctrl_pkg.sv | 40 ++++
 rtl/cursor_next_pos.sv | 61 ++++++
 rtl/cursor_pos_ctrl.sv | 124 ++++++++++++
 tb/tb_cursor_pos_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cursor_pos_ctrl_pkg.sv
// Common cursor/text definitions shared by the cursor position controller
// and its next-position logic: grid geometry, key codes, state encodings.
package cursor_pos_ctrl_pkg;

  localparam int CELL_W = 8;
  localparam int CELL_H = 12;
  localparam int COLS   = 40;
  localparam int ROWS   = 19;

  localparam int COL_W = 6;
  localparam int ROW_W = 5;
  localparam int PIX_W = 9;
  localparam int CNT_W = 5;

  localparam logic [2:0] KEY_RIGHT     = 3'd0;
  localparam logic [2:0] KEY_LEFT      = 3'd1;
  localparam logic [2:0] KEY_UP        = 3'd2;
  localparam logic [2:0] KEY_DOWN      = 3'd3;
  localparam logic [2:0] KEY_HOME      = 3'd4;
  localparam logic [2:0] KEY_NEWLINE   = 3'd5;
  localparam logic [2:0] KEY_BACKSPACE = 3'd6;
  localparam logic [2:0] KEY_ADVANCE   = 3'd7;

  // Bit 0 is set in every busy state, so blink/key_ready come straight off
  // one flop and cannot glitch on state transitions.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_HIDE   = 2'b01,
    ST_SETTLE = 2'b11
  } state_t;

  function automatic logic [PIX_W-1:0] cell_x(input logic [COL_W-1:0] c);
    return PIX_W'(c) * PIX_W'(CELL_W);
  endfunction

  function automatic logic [PIX_W-1:0] cell_y(input logic [ROW_W-1:0] r);
    return PIX_W'(r) * PIX_W'(CELL_H);
  endfunction

endpackage

// File: rtl/cursor_next_pos.sv
// Next cursor cell for a key command: all wrap and saturation rules live
// here. Purely combinational.
module cursor_next_pos
  import cursor_pos_ctrl_pkg::*;
(
  input  logic [COL_W-1:0] col,
  input  logic [ROW_W-1:0] row,
  input  logic [2:0]       key_code,
  output logic [COL_W-1:0] next_col,
  output logic [ROW_W-1:0] next_row,
  output logic             moved
);

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_ONE = COL_W'(1);
  localparam logic [ROW_W-1:0] ROW_ONE = ROW_W'(1);

  // Apply the command to the current cell; the grid corners are sticky.
  always_comb begin
    next_col = col;
    next_row = row;
    case (key_code)
      KEY_RIGHT, KEY_ADVANCE: begin
        if (col != COL_MAX) begin
          next_col = col + COL_ONE;
        end else if (row != ROW_MAX) begin
          next_col = '0;
          next_row = row + ROW_ONE;
        end
      end
      KEY_LEFT, KEY_BACKSPACE: begin
        if (col != '0) begin
          next_col = col - COL_ONE;
        end else if (row != '0) begin
          next_col = COL_MAX;
          next_row = row - ROW_ONE;
        end
      end
      KEY_UP: begin
        if (row != '0) next_row = row - ROW_ONE;
      end
      KEY_DOWN: begin
        if (row != ROW_MAX) next_row = row + ROW_ONE;
      end
      KEY_HOME: begin
        next_col = '0;
      end
      KEY_NEWLINE: begin
        next_col = '0;
        if (row != ROW_MAX) next_row = row + ROW_ONE;
      end
      default: begin
        next_col = col;
        next_row = row;
      end
    endcase
    moved = (next_col != col) || (next_row != row);
  end

endmodule

// File: rtl/cursor_pos_ctrl.sv
// Cursor position controller. Accepts key commands, hides the cursor at the
// old cell for HIDE_CYCLES (13..32, counter is 5 bits), publishes the new
// cell, waits two cycles for the drawer to pick it up, then re-enables blink.
//
// state  | meaning
// IDLE   | blink on, ready for a command
// HIDE   | blink off, old position still shown so the drawer can erase it
// SETTLE | blink off, new position shown, drawer copy catching up (2 cycles)
module cursor_pos_ctrl
  import cursor_pos_ctrl_pkg::*;
#(
  parameter int HIDE_CYCLES = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             key_valid,
  input  logic [2:0]       key_code,
  output logic             key_ready,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic [PIX_W-1:0] block_x,
  output logic [PIX_W-1:0] block_y,
  output logic             blink
);

  localparam logic [CNT_W-1:0] HIDE_LAST   = CNT_W'(HIDE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [COL_W-1:0] pend_col;
  logic [ROW_W-1:0] pend_row;
  logic [COL_W-1:0] next_col;
  logic [ROW_W-1:0] next_row;
  logic             moved;
  logic             load_pend;
  logic             load_pos;

  cursor_next_pos u_next_pos (
    .col      (col),
    .row      (row),
    .key_code (key_code),
    .next_col (next_col),
    .next_row (next_row),
    .moved    (moved)
  );

  // State and phase counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state, counter and load strobes; blink/ready decoded from state.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load_pend  = 1'b0;
    load_pos   = 1'b0;
    blink      = ~state[0];
    key_ready  = ~state[0];
    case (state)
      ST_IDLE: begin
        // A command that does not move the cursor is consumed silently.
        if (key_valid && moved) begin
          load_pend  = 1'b1;
          cnt_next   = '0;
          state_next = ST_HIDE;
        end
      end
      ST_HIDE: begin
        cnt_next = cnt + CNT_ONE;
        if (cnt == HIDE_LAST) begin
          load_pos   = 1'b1;
          cnt_next   = '0;
          state_next = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        cnt_next = cnt + CNT_ONE;
        if (cnt == SETTLE_LAST) begin
          cnt_next   = '0;
          state_next = ST_IDLE;
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = ST_IDLE;
      end
    endcase
  end

  // Pending target and published position; all four outputs share one edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_col <= '0;
      pend_row <= '0;
      col      <= '0;
      row      <= '0;
      block_x  <= '0;
      block_y  <= '0;
    end else begin
      if (load_pend) begin
        pend_col <= next_col;
        pend_row <= next_row;
      end
      if (load_pos) begin
        col     <= pend_col;
        row     <= pend_row;
        block_x <= cell_x(pend_col);
        block_y <= cell_y(pend_row);
      end
    end
  end

endmodule

// File: tb/tb_cursor_pos_ctrl.sv
// Bench for cursor_pos_ctrl: directed scenarios plus random key traffic,
// compared every cycle against a timestamp-based reference model.
module tb_cursor_pos_ctrl;

  localparam int T_COLS = 40;
  localparam int T_ROWS = 19;
  localparam int T_CW   = 8;
  localparam int T_CH   = 12;
  localparam int HIDE   = 16;

  localparam int K_RIGHT = 0, K_LEFT = 1, K_UP = 2, K_DOWN = 3;
  localparam int K_HOME = 4, K_NL = 5, K_BS = 6, K_ADV = 7;

  logic       clock = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [2:0] key_code;
  logic       key_ready;
  logic [5:0] col;
  logic [4:0] row;
  logic [8:0] block_x;
  logic [8:0] block_y;
  logic       blink;

  cursor_pos_ctrl #(.HIDE_CYCLES(HIDE)) dut (
    .clock     (clock),
    .reset     (reset),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .col       (col),
    .row       (row),
    .block_x   (block_x),
    .block_y   (block_y),
    .blink     (blink)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: shown cell, pending cell, and the cycle a move was taken.
  int m_col = 0, m_row = 0, p_col = 0, p_row = 0;
  int t_acc = 0, cyc = 0;
  bit busy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Moves along the text as a linear character index; vertical moves clamp.
  function automatic void model_next(input int code, input int c, input int r,
                                     output int nc, output int nr);
    int idx;
    idx = r * T_COLS + c;
    nc = c;
    nr = r;
    case (code)
      K_RIGHT, K_ADV: begin
        if (idx < T_COLS * T_ROWS - 1) idx++;
        nc = idx % T_COLS;
        nr = idx / T_COLS;
      end
      K_LEFT, K_BS: begin
        if (idx > 0) idx--;
        nc = idx % T_COLS;
        nr = idx / T_COLS;
      end
      K_UP:    nr = (r > 0) ? r - 1 : 0;
      K_DOWN:  nr = (r < T_ROWS - 1) ? r + 1 : T_ROWS - 1;
      K_HOME:  nc = 0;
      K_NL: begin
        nc = 0;
        nr = (r < T_ROWS - 1) ? r + 1 : T_ROWS - 1;
      end
      default: ;
    endcase
  endfunction

  task automatic check_all();
    chk("col", col, m_col);
    chk("row", row, m_row);
    chk("block_x", block_x, m_col * T_CW);
    chk("block_y", block_y, m_row * T_CH);
    chk("blink", blink, busy ? 0 : 1);
    chk("key_ready", key_ready, busy ? 0 : 1);
  endtask

  // One clock: update model for the edge, then check at the falling edge.
  task automatic tick();
    bit acc;
    int kc, t, nc, nr;
    acc = key_valid && !busy;
    kc  = int'(key_code);
    t   = cyc;
    @(posedge clock);
    cyc++;
    if (busy && cyc == t_acc + HIDE + 1) begin
      m_col = p_col;
      m_row = p_row;
    end
    if (busy && cyc == t_acc + HIDE + 3) busy = 1'b0;
    if (acc) begin
      model_next(kc, m_col, m_row, nc, nr);
      if (nc != m_col || nr != m_row) begin
        busy  = 1'b1;
        t_acc = t;
        p_col = nc;
        p_row = nr;
      end
    end
    @(negedge clock);
    check_all();
  endtask

  task automatic idle(input int n);
    key_valid = 1'b0;
    repeat (n) tick();
  endtask

  // Wait (bounded) for ready, then present one command for one cycle.
  task automatic send(input int code);
    int w;
    w = 0;
    key_valid = 1'b0;
    while (busy && w < 40) begin
      tick();
      w++;
    end
    if (busy) chk("wait_ready", key_ready, 1);
    key_valid = 1'b1;
    key_code  = 3'(code);
    tick();
    key_valid = 1'b0;
  endtask

  task automatic send_n(input int code, input int n);
    repeat (n) send(code);
  endtask

  initial begin
    reset     = 1'b0;
    key_valid = 1'b0;
    key_code  = 3'd0;
    repeat (3) @(negedge clock);
    check_all();
    reset = 1'b1;

    // First move: old cell held through HIDE, new cell at t+17, ready at t+19.
    send(K_RIGHT);
    repeat (15) tick();
    chk("t1_bx_hide_end", block_x, 0);
    tick();
    chk("t1_bx_new", block_x, 8);
    chk("t1_col_new", col, 1);
    repeat (2) tick();
    chk("t1_ready_t19", key_ready, 1);
    chk("t1_blink_t19", blink, 1);

    // Right-edge wrap, then the bottom-right corner sticks.
    send_n(K_RIGHT, 38);
    send(K_ADV);
    idle(HIDE + 3);
    chk("adv_wrap_by", block_y, 12);
    send_n(K_DOWN, 17);
    send(K_LEFT);
    send(K_DOWN);
    idle(HIDE + 3);
    send(K_ADV);
    idle(20);
    chk("adv_corner_ready", key_ready, 1);

    // Left-edge wrap with backspace, then the top-left corner sticks.
    send_n(K_UP, 15);
    send(K_RIGHT);
    send(K_UP);
    send(K_BS);
    idle(HIDE + 3);
    chk("bs_wrap_bx", block_x, 312);
    chk("bs_wrap_by", block_y, 24);
    send(K_HOME);
    send_n(K_UP, 2);
    send(K_LEFT);
    idle(3);
    send(K_UP);
    idle(3);

    // Bottom row: DOWN saturates, NEWLINE behaves as HOME.
    send_n(K_DOWN, 18);
    send(K_DOWN);
    idle(3);
    send_n(K_RIGHT, 17);
    send(K_NL);
    idle(HIDE + 3);
    chk("nl_last_bx", block_x, 0);

    // Held key_valid with another code while busy is ignored until IDLE.
    send(K_RIGHT);
    key_valid = 1'b1;
    key_code  = 3'(K_UP);
    repeat (20) tick();
    key_valid = 1'b0;
    idle(HIDE + 3);

    // Reset in the middle of HIDE discards the move.
    send(K_HOME);
    send_n(K_UP, 13);
    send_n(K_RIGHT, 5);
    send(K_RIGHT);
    repeat (7) tick();
    reset = 1'b0;
    #1;
    m_col = 0;
    m_row = 0;
    busy  = 1'b0;
    check_all();
    chk("rst_mid_blink", blink, 1);
    #1 reset = 1'b1;
    send(K_RIGHT);
    idle(HIDE + 3);
    chk("after_rst_col", col, 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      key_valid = ($urandom_range(3) != 0);
      key_code  = 3'($urandom_range(7));
      tick();
    end
    idle(HIDE + 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
